// File: rtl/bar_graph_scheduler.sv
// Walks every bar slot in order, erasing each column in background colour and redrawing it at its stored height.
// One slot per erase/draw pass of the external drawer; start and writes are accepted only while idle.
module bar_graph_scheduler #(
  parameter int         NUM_BARS   = 8,
  parameter int         BAR_PITCH  = 12,
  parameter int         BASE_X     = 20,
  parameter int         BASE_Y     = 220,
  parameter int         MAX_HEIGHT = 200,
  parameter logic [2:0] BAR_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_height,
  input  logic       drawer_done,
  output logic       drawer_resetn,
  output logic       drawer_enable,
  output logic [8:0] drawer_start_x,
  output logic [7:0] drawer_start_y,
  output logic [7:0] drawer_height,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] MAX_H     = 8'(MAX_HEIGHT);
  localparam logic [3:0] NB        = 4'(NUM_BARS);
  localparam logic [2:0] LAST_SLOT = 3'(NUM_BARS - 1);
  localparam logic [8:0] X0        = 9'(BASE_X);
  localparam logic [8:0] PITCH     = 9'(BAR_PITCH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR_E = 3'd1,
    ERASE = 3'd2,
    CLR_D = 3'd3,
    DRAW  = 3'd4,
    NEXT  = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] slot, slot_nxt;
  logic [7:0] heights [8];
  logic [7:0] cur_h;
  logic       wr_ok;
  logic [7:0] wr_val;

  assign cur_h  = heights[slot];
  assign wr_ok  = wr_en && (state == IDLE) && ({1'b0, wr_idx} < NB);
  assign wr_val = (wr_height > MAX_H) ? MAX_H : wr_height;

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLR_E;
          slot_nxt  = 3'd0;
        end
      end
      CLR_E: state_nxt = ERASE;
      ERASE: begin
        if (drawer_done) state_nxt = (cur_h != 8'd0) ? CLR_D : NEXT;
      end
      CLR_D: state_nxt = DRAW;
      DRAW: begin
        if (drawer_done) state_nxt = NEXT;
      end
      NEXT: begin
        if (slot == LAST_SLOT) begin
          state_nxt = FIN;
        end else begin
          state_nxt = CLR_E;
          slot_nxt  = slot + 3'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      slot  <= 3'd0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) heights[i] <= 8'd0;
    end else if (wr_ok) begin
      heights[wr_idx] <= wr_val;
    end
  end

  // Outputs are registered from the next state so each phase sees them in its own cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drawer_resetn <= 1'b0;
      drawer_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      colour        <= BG_COLOUR;
      drawer_height <= 8'd0;
    end else begin
      drawer_resetn <= !((state_nxt == CLR_E) || (state_nxt == CLR_D));
      drawer_enable <= (state_nxt == ERASE) || (state_nxt == DRAW);
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == FIN);
      if (state_nxt == CLR_E) begin
        colour        <= BG_COLOUR;
        drawer_height <= MAX_H;
      end else if (state_nxt == CLR_D) begin
        colour        <= BAR_COLOUR;
        drawer_height <= cur_h;
      end
    end
  end

  assign drawer_start_x = X0 + 9'(slot) * PITCH;
  assign drawer_start_y = 8'(BASE_Y);
  assign plot           = drawer_enable & ~drawer_done;

endmodule

// File: tb/tb_bar_graph_scheduler.sv
// Directed bench: default 8-slot instance plus a 1-slot instance, each driving a simple drawer model.
module tb_bar_graph_scheduler;

  logic       clk;
  logic       resetn;
  logic       start_a, start_b;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_height;

  logic       dd_a, drst_a, den_a, plot_a, busy_a, done_a;
  logic [8:0] sx_a;
  logic [7:0] sy_a, h_a;
  logic [2:0] col_a;
  logic       dd_b, drst_b, den_b, plot_b, busy_b, done_b;
  logic [8:0] sx_b;
  logic [7:0] sy_b, h_b;
  logic [2:0] col_b;

  bar_graph_scheduler dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_height(wr_height), .drawer_done(dd_a), .drawer_resetn(drst_a),
    .drawer_enable(den_a), .drawer_start_x(sx_a), .drawer_start_y(sy_a),
    .drawer_height(h_a), .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  bar_graph_scheduler #(.NUM_BARS(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_height(wr_height), .drawer_done(dd_b), .drawer_resetn(drst_b),
    .drawer_enable(den_b), .drawer_start_x(sx_b), .drawer_start_y(sy_b),
    .drawer_height(h_b), .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  // Drawer models: done after (h+1)*8 enabled cycles, cleared while drawer_resetn is low.
  logic [10:0] cnt_a = '0;
  logic [10:0] cnt_b = '0;
  always @(posedge clk) begin
    if (!drst_a) cnt_a <= '0;
    else if (den_a && !dd_a) cnt_a <= cnt_a + 11'd1;
    if (!drst_b) cnt_b <= '0;
    else if (den_b && !dd_b) cnt_b <= cnt_b + 11'd1;
  end
  assign dd_a = (cnt_a == ({3'b000, h_a} + 11'd1) * 11'd8);
  assign dd_b = (cnt_b == ({3'b000, h_b} + 11'd1) * 11'd8);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       sel;
  logic       m_busy, m_done, m_rstn, m_plot;
  logic [2:0] m_col;
  logic [7:0] m_h;
  logic [8:0] m_x;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_rstn = sel ? drst_b : drst_a;
  assign m_plot = sel ? plot_b : plot_a;
  assign m_col  = sel ? col_b  : col_a;
  assign m_h    = sel ? h_b    : h_a;
  assign m_x    = sel ? sx_b   : sx_a;

  int n_cmp = 0;
  int n_err = 0;

  int bg_plots, bar_plots, odd_col, rst_lo, done_cnt, done_cyc, first_x, got_done;
  int first_busy, first_rstn, first_h, busy_after;
  int bar_h [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start on the selected instance and gathers per-run statistics until a few cycles after done.
  task automatic run_seq(input bit use_b, input bit hammer);
    int cyc;
    int s;
    bg_plots = 0; bar_plots = 0; odd_col = 0; rst_lo = 0;
    done_cnt = 0; done_cyc = 0; first_x = -1; got_done = 0; busy_after = 1;
    for (int i = 0; i < 8; i++) bar_h[i] = 0;
    sel = use_b;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; wr_en = 1'b0;
    first_busy = int'(m_busy);
    first_rstn = int'(m_rstn);
    first_h    = int'(m_h);
    cyc = 0;
    while (cyc < 20000 && !(got_done != 0 && cyc >= done_cyc + 4)) begin
      cyc++;
      if (!m_rstn) rst_lo++;
      if (m_done) begin
        done_cnt++;
        if (got_done == 0) done_cyc = cyc;
        got_done = 1;
      end
      if (got_done != 0 && cyc == done_cyc + 1) busy_after = int'(m_busy);
      if (m_plot) begin
        if (first_x < 0) first_x = int'(m_x);
        if (m_col == 3'b000) bg_plots++;
        else if (m_col == 3'b010) begin
          bar_plots++;
          if (m_x >= 9'd20) begin
            s = (int'(m_x) - 20) / 12;
            if (s < 8) bar_h[s] = int'(m_h);
          end
        end else odd_col++;
      end
      if (hammer && got_done == 0 && m_busy && (cyc % 40) == 5) begin
        start_a = 1'b1; wr_en = 1'b1; wr_idx = 3'd1; wr_height = 8'd9;
      end else if (hammer) begin
        start_a = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0; wr_en = 1'b0;
    check("seq_done_seen", got_done, 1);
  endtask

  initial begin
    int found;
    resetn = 1'b0; start_a = 1'b0; start_b = 1'b0;
    wr_en = 1'b0; wr_idx = 3'd0; wr_height = 8'd0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_enable", den_a, 0);
    check("rst_drawer_resetn", drst_a, 0);
    check("rst_plot", plot_a, 0);
    check("rst_colour", col_a, 0);
    check("rst_height", h_a, 0);
    check("rst_b_busy", busy_b, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_drawer_resetn", drst_a, 1);
    check("start_y_a", sy_a, 220);
    check("start_y_b", sy_b, 220);

    // All heights zero: erase-only slots.
    run_seq(1'b0, 1'b0);
    check("t1_first_busy", first_busy, 1);
    check("t1_first_rstn", first_rstn, 0);
    check("t1_first_height", first_h, 200);
    check("t1_bg_plots", bg_plots, 12864);
    check("t1_bar_plots", bar_plots, 0);
    check("t1_odd_colour", odd_col, 0);
    check("t1_rst_lo", rst_lo, 8);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, 12889);
    check("t1_busy_after", busy_after, 0);

    // Write slot 2 height 3 in the same cycle as start.
    wr_en = 1'b1; wr_idx = 3'd2; wr_height = 8'd3;
    run_seq(1'b0, 1'b0);
    check("t2_bar_plots", bar_plots, 32);
    check("t2_bar_h2", bar_h[2], 3);
    check("t2_first_bar_x", (bar_plots > 0) ? 44 : 0, 44);
    check("t2_bg_plots", bg_plots, 12864);
    check("t2_rst_lo", rst_lo, 9);
    check("t2_done_cyc", done_cyc, 12923);

    // Clamp slot 0, set slot 1 to 2, then hammer start/writes while busy.
    wr_en = 1'b1; wr_idx = 3'd0; wr_height = 8'd250;
    @(negedge clk);
    wr_idx = 3'd1; wr_height = 8'd2;
    @(negedge clk);
    wr_en = 1'b0;
    run_seq(1'b0, 1'b1);
    check("t3_bar_h0_clamped", bar_h[0], 200);
    check("t3_bar_h1", bar_h[1], 2);
    check("t3_bar_plots", bar_plots, 1664);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_done_cyc", done_cyc, 14559);
    check("t3_busy_after", busy_after, 0);
    repeat (20) @(negedge clk);
    check("t4_no_restart", busy_a, 0);

    // Readback run with slot 0 cleared: slot 1 must still be 2.
    wr_en = 1'b1; wr_idx = 3'd0; wr_height = 8'd0;
    @(negedge clk);
    wr_en = 1'b0;
    run_seq(1'b0, 1'b0);
    check("t4_bar_h1_old", bar_h[1], 2);
    check("t4_bar_plots", bar_plots, 56);
    check("t4_done_cyc", done_cyc, 12949);

    // Reset in the middle of slot 4 erase.
    wr_en = 1'b1; wr_idx = 3'd3; wr_height = 8'd7;
    @(negedge clk);
    wr_en = 1'b0;
    sel = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 20000 && found == 0; i++) begin
      if (sx_a == 9'd68 && den_a) found = 1;
      else @(negedge clk);
    end
    check("t5_slot4_erase_seen", found, 1);
    repeat (100) @(negedge clk);
    check("t5_pre_colour_bg", col_a, 0);
    #2 resetn = 1'b0;
    #1;
    check("t5_busy", busy_a, 0);
    check("t5_done", done_a, 0);
    check("t5_enable", den_a, 0);
    check("t5_drawer_resetn", drst_a, 0);
    check("t5_plot", plot_a, 0);
    check("t5_colour", col_a, 0);
    check("t5_height", h_a, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_seq(1'b0, 1'b0);
    check("t5_first_x", first_x, 20);
    check("t5_bar_plots", bar_plots, 0);
    check("t5_done_cyc", done_cyc, 12889);

    // One-slot instance, height 1; write to slot 3 is out of range.
    wr_en = 1'b1; wr_idx = 3'd3; wr_height = 8'd5;
    @(negedge clk);
    wr_idx = 3'd0; wr_height = 8'd1;
    run_seq(1'b1, 1'b0);
    check("t6_bar_plots", bar_plots, 16);
    check("t6_bar_h0", bar_h[0], 1);
    check("t6_bg_plots", bg_plots, 1608);
    check("t6_rst_lo", rst_lo, 2);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_done_cyc", done_cyc, 1630);
    check("t6_a_idle", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
